// File: rtl/pdm_pkg.sv
// Shared constants for the PDM modulator: integrator headroom above the sample
// width and the full-scale feedback magnitude for a given sample width.
package pdm_pkg;

    localparam int ACC_EXT = 4;

    function automatic longint fs_feedback(input int width);
        return longint'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/pdm_sd_core.sv
// One sigma-delta channel: first order by default, second order when
// PDM_ORDER2_EN is defined. Integrators saturate instead of wrapping.
module pdm_sd_core
    import pdm_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    step,
    input  logic signed [WIDTH-1:0] x,
    output logic                    bit_o
);

    localparam int AW = WIDTH + ACC_EXT;
    // Two guard bits so acc + x - fb can never overflow before the clamp.
    localparam int SW = AW + 2;
    localparam logic signed [SW-1:0] FS      = SW'(fs_feedback(WIDTH));
    localparam logic signed [SW-1:0] ACC_MAX = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    function automatic logic signed [SW-1:0] ext(input logic signed [AW-1:0] v);
        return {{(SW-AW){v[AW-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] c;
        if (v > ACC_MAX)      c = ACC_MAX;
        else if (v < ACC_MIN) c = ACC_MIN;
        else                  c = v;
        return c[AW-1:0];
    endfunction

    logic signed [AW-1:0] acc1_q, acc1_d;
    logic signed [SW-1:0] x_ext;
    logic signed [SW-1:0] fb;
    logic                 fb_bit;

`ifdef PDM_ORDER2_EN
    logic signed [AW-1:0] acc2_q, acc2_d;
    assign fb_bit = ~acc2_q[AW-1];
`else
    assign fb_bit = ~acc1_q[AW-1];
`endif

    assign x_ext = {{(SW-WIDTH){x[WIDTH-1]}}, x};
    assign fb    = fb_bit ? FS : -FS;
    assign bit_o = fb_bit;

    always_comb begin
        acc1_d = acc1_q;
`ifdef PDM_ORDER2_EN
        acc2_d = acc2_q;
`endif
        if (step) begin
            acc1_d = sat(ext(acc1_q) + x_ext - fb);
`ifdef PDM_ORDER2_EN
            acc2_d = sat(ext(acc2_q) + ext(acc1_d) - fb);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc1_q <= '0;
`ifdef PDM_ORDER2_EN
            acc2_q <= '0;
`endif
        end else begin
            acc1_q <= acc1_d;
`ifdef PDM_ORDER2_EN
            acc2_q <= acc2_d;
`endif
        end
    end

endmodule

// File: rtl/pdm_modulator.sv
// Stereo DDR PDM modulator with a one-deep sample-pair buffer and frame-based
// hold registers. Define PDM_ORDER2_EN for second-order channel loops.
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int CLK_DIV = 1,
    parameter int OSR     = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] s_dataR,
    input  logic signed [WIDTH-1:0] s_dataF,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    pdm_clk,
    output logic                    pdm_data,
    output logic                    load_strobe,
    output logic                    underrun
);

    localparam int HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PCW = $clog2(OSR);
    localparam logic [HCW-1:0] HC_LAST = HCW'(CLK_DIV - 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(OSR - 1);

    logic [HCW-1:0]          hc_q, hc_d;
    logic [PCW-1:0]          pc_q, pc_d;
    logic                    pdm_clk_q, pdm_clk_d;
    logic                    pdm_data_q, pdm_data_d;
    logic                    ls_q, ls_d;
    logic                    ur_q, ur_d;
    logic                    full_q, full_d;
    logic signed [WIDTH-1:0] buf_r_q, buf_r_d, buf_f_q, buf_f_d;
    logic signed [WIDTH-1:0] hold_r_q, hold_r_d, hold_f_q, hold_f_d;

    logic                    tc, rise, fall, frame_start, load, xfer;
    logic                    bit_r, bit_f;
    logic signed [WIDTH-1:0] x_r;

    assign tc          = (hc_q == HC_LAST);
    assign rise        = tc & ~pdm_clk_q;
    assign fall        = tc & pdm_clk_q;
    assign frame_start = rise & (pc_q == '0);
    assign load        = frame_start & full_q;
    assign xfer        = s_valid & ~full_q;
    // The frame-start R step already integrates the sample being loaded.
    assign x_r         = load ? buf_r_q : hold_r_q;

    pdm_sd_core #(.WIDTH(WIDTH)) u_core_r (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (rise),
        .x       (x_r),
        .bit_o   (bit_r)
    );

    pdm_sd_core #(.WIDTH(WIDTH)) u_core_f (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (fall),
        .x       (hold_f_q),
        .bit_o   (bit_f)
    );

    always_comb begin
        hc_d       = tc ? '0 : hc_q + 1'b1;
        pdm_clk_d  = pdm_clk_q ^ tc;
        pc_d       = pc_q;
        if (fall) pc_d = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;

        pdm_data_d = pdm_data_q;
        if (rise)      pdm_data_d = bit_r;
        else if (fall) pdm_data_d = bit_f;

        ls_d     = frame_start;
        ur_d     = frame_start & ~full_q;

        full_d   = full_q;
        buf_r_d  = buf_r_q;
        buf_f_d  = buf_f_q;
        hold_r_d = hold_r_q;
        hold_f_d = hold_f_q;
        if (load) begin
            hold_r_d = buf_r_q;
            hold_f_d = buf_f_q;
            full_d   = 1'b0;
        end
        // A transfer only happens into an empty buffer, so it never races a load.
        if (xfer) begin
            full_d  = 1'b1;
            buf_r_d = s_dataR;
            buf_f_d = s_dataF;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q       <= '0;
            pc_q       <= '0;
            pdm_clk_q  <= 1'b0;
            pdm_data_q <= 1'b0;
            ls_q       <= 1'b0;
            ur_q       <= 1'b0;
            full_q     <= 1'b0;
            buf_r_q    <= '0;
            buf_f_q    <= '0;
            hold_r_q   <= '0;
            hold_f_q   <= '0;
        end else begin
            hc_q       <= hc_d;
            pc_q       <= pc_d;
            pdm_clk_q  <= pdm_clk_d;
            pdm_data_q <= pdm_data_d;
            ls_q       <= ls_d;
            ur_q       <= ur_d;
            full_q     <= full_d;
            buf_r_q    <= buf_r_d;
            buf_f_q    <= buf_f_d;
            hold_r_q   <= hold_r_d;
            hold_f_q   <= hold_f_d;
        end
    end

    assign s_ready     = ~full_q;
    assign pdm_clk     = pdm_clk_q;
    assign pdm_data    = pdm_data_q;
    assign load_strobe = ls_q;
    assign underrun    = ur_q;

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator against an edge-indexed behavioural model.
module tb_pdm_modulator;

    localparam int W  = 12;
    localparam int CD = 3;
    localparam int OS = 4;
    localparam longint FS  = longint'(1) << (W - 1);
    localparam longint LIM = longint'(1) << (W + 3);
    localparam int FRAME = 2 * CD * OS;

    logic                clk = 1'b0;
    logic                reset_n;
    logic signed [W-1:0] s_dataR, s_dataF;
    logic                s_valid;
    logic                s_ready, pdm_clk, pdm_data, load_strobe, underrun;

    int checks = 0;
    int errors = 0;

    pdm_modulator #(.WIDTH(W), .CLK_DIV(CD), .OSR(OS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_dataR     (s_dataR),
        .s_dataF     (s_dataF),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .pdm_clk     (pdm_clk),
        .pdm_data    (pdm_data),
        .load_strobe (load_strobe),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Model state: n counts clk edges since reset release.
    int     n;
    bit     m_full;
    longint m_buf[2], m_hold[2], acc1[2], acc2[2];
    bit     e_clk, e_data, e_ls, e_ur, e_rise, e_fall;

    function automatic longint clamp(input longint v);
        if (v > LIM - 1) return LIM - 1;
        if (v < -LIM)    return -LIM;
        return v;
    endfunction

    function automatic bit is_fs(input int k);
        int t;
        if (k <= 0 || (k % CD) != 0) return 1'b0;
        t = k / CD;
        if ((t % 2) == 0) return 1'b0;
        return (((t - 1) / 2) % OS) == 0;
    endfunction

    function automatic logic signed [W-1:0] rnd_sample();
        case ($urandom_range(0, 3))
            0:       return {1'b1, {(W-1){1'b0}}};
            1:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic mstep(input int ch, input longint x, output bit b);
        longint fb;
`ifdef PDM_ORDER2_EN
        b = (acc2[ch] >= 0);
`else
        b = (acc1[ch] >= 0);
`endif
        fb = b ? FS : -FS;
        acc1[ch] = clamp(acc1[ch] + x - fb);
`ifdef PDM_ORDER2_EN
        acc2[ch] = clamp(acc2[ch] + acc1[ch] - fb);
`endif
    endtask

    task automatic model_reset();
        n = 0;
        m_full = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_buf[c] = 0; m_hold[c] = 0; acc1[c] = 0; acc2[c] = 0;
        end
        e_clk = 0; e_data = 0; e_ls = 0; e_ur = 0; e_rise = 0; e_fall = 0;
    endtask

    task automatic model_edge();
        bit xfer, b;
        int t;
        n++;
        xfer   = s_valid && !m_full;
        e_ls   = 0; e_ur = 0; e_rise = 0; e_fall = 0;
        if ((n % CD) == 0) begin
            t = n / CD;
            if ((t % 2) == 1) begin
                e_clk = 1; e_rise = 1;
                if ((((t - 1) / 2) % OS) == 0) begin
                    e_ls = 1;
                    if (m_full) begin
                        m_hold[0] = m_buf[0];
                        m_hold[1] = m_buf[1];
                        m_full    = 0;
                    end else begin
                        e_ur = 1;
                    end
                end
                mstep(0, m_hold[0], b);
                e_data = b;
            end else begin
                e_clk = 0; e_fall = 1;
                mstep(1, m_hold[1], b);
                e_data = b;
            end
        end
        if (xfer) begin
            m_full   = 1;
            m_buf[0] = longint'(s_dataR);
            m_buf[1] = longint'(s_dataF);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at n=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        chk("pdm_clk",     32'(pdm_clk),     32'(e_clk));
        chk("pdm_data",    32'(pdm_data),    32'(e_data));
        chk("load_strobe", 32'(load_strobe), 32'(e_ls));
        chk("underrun",    32'(underrun),    32'(e_ur));
        chk("s_ready",     32'(s_ready),     32'(!m_full));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    bit qr[$], qf[$];
    bit exp_r[4];
    bit exp_f[4];
    int ur_seen;

    initial begin
        exp_r = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_f = '{1'b1, 1'b0, 1'b1, 1'b0};
        reset_n = 1'b1; s_valid = 1'b0; s_dataR = '0; s_dataF = '0;
        #1 reset_n = 1'b0;
        #2;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Idle: every frame underruns, streams alternate.
        repeat (2 * FRAME + 10) tick();

        // Fill the buffer, then reset mid-frame.
        s_valid = 1'b1; s_dataR = rnd_sample(); s_dataF = rnd_sample();
        tick();
        s_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Pair (+1024, 0) accepted before the first frame start.
        s_valid = 1'b1; s_dataR = W'(1024); s_dataF = '0;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < FRAME + 6; i++) begin
            tick();
            if (e_rise) qr.push_back(pdm_data);
            if (e_fall) qf.push_back(pdm_data);
        end
        for (int i = 0; i < 4; i++) begin
            chk("r_pattern", 32'(qr[i]), 32'(exp_r[i]));
            chk("f_pattern", 32'(qf[i]), 32'(exp_f[i]));
        end

        // s_valid held high: one transfer per frame, never an underrun.
        ur_seen = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 6 * FRAME; i++) begin
            s_dataR = rnd_sample(); s_dataF = rnd_sample();
            tick();
            if (i > FRAME && underrun) ur_seen++;
        end
        chk("held_no_underrun", 32'(ur_seen), 32'd0);

        // Transfer coincident with a frame start on an empty buffer.
        s_valid = 1'b0;
        repeat (FRAME + 4) tick();
        for (int i = 0; i < 2 * FRAME && !is_fs(n + 1); i++) tick();
        s_valid = 1'b1; s_dataR = rnd_sample(); s_dataF = rnd_sample();
        tick();
        chk("coincident_underrun", 32'(underrun), 32'd1);
        s_valid = 1'b0;
        repeat (2 * FRAME) tick();

        // Random traffic.
        for (int i = 0; i < 10 * FRAME; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_dataR = rnd_sample(); s_dataF = rnd_sample();
            tick();
        end

`ifndef PDM_ORDER2_EN
        // Steady negative full scale settles to an all-zero stream.
        s_valid = 1'b1;
        s_dataR = {1'b1, {(W-1){1'b0}}};
        s_dataF = {1'b1, {(W-1){1'b0}}};
        repeat (4 * FRAME) tick();
        for (int i = 0; i < FRAME; i++) begin
            tick();
            chk("negfs_zero", 32'(pdm_data), 32'd0);
        end
        s_valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
